aes_key_expansion_multi: RTL and testbench

Parametrised AES key-schedule engine that generalises the fixed-length expanders to AES-128, AES-192 and AES-256, with the key length selected per run. It generates one 32-bit schedule word per cycle. Every fourth word it emits a complete 128-bit round key on a valid/ready stream toward the round datapath. Downstream back-pressure stalls generation without losing or duplicating keys.

---
 rtl/aes_key_expansion_multi.sv | 176 +++++++++++++++++
 tb/tb_aes_key_expansion_multi.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expansion_multi.sv
// AES-128/192/256 key schedule, one 32-bit word per cycle.
// Round keys leave four words at a time on a valid/ready stream.
module aes_key_expansion_multi #(
  parameter int MAX_KEY_BITS = 256,
  parameter int SBOX_INST    = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] short_key,
  output logic [127:0] subkey,
  output logic         subkey_valid,
  input  logic         subkey_ready,
  output logic [3:0]   round_idx,
  output logic         busy,
  output logic         done
);
  typedef enum logic [1:0] {IDLE, GEN, DRAIN} state_e;

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p, x, y;
    p = '0;
    x = a;
    y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // Inverse as a^254 in GF(2^8) (0 maps to 0), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] t, v;
    t = gmul(gmul(a, a), a);
    t = gmul(gmul(t, t), a);
    t = gmul(gmul(t, t), a);
    t = gmul(gmul(t, t), a);
    t = gmul(gmul(t, t), a);
    t = gmul(gmul(t, t), a);
    v = gmul(t, t);
    return v ^ {v[3:0], v[7:4]} ^ {v[4:0], v[7:5]}
             ^ {v[5:0], v[7:6]} ^ {v[6:0], v[7]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] r;
    r = w;
    for (int b = 0; b < SBOX_INST; b++)
      r[8*b +: 8] = sbox(w[8*b +: 8]);
    return r;
  endfunction

  state_e       state_q;
  logic [31:0]  win_q [8];
  logic [255:0] key_q;
  logic [5:0]   i_q;
  logic [5:0]   last_q;
  logic [2:0]   cnt_q;
  logic [2:0]   nkm1_q;
  logic [7:0]   rcon_q;
  logic [127:0] subkey_q;
  logic         sv_q;
  logic [3:0]   ridx_q;
  logic         busy_q;
  logic         done_q;

  logic [31:0]  w_d;
  logic [31:0]  mix;
  logic         key_ph;
  logic         adv;
  logic         legal;

  // win_q[0] is w[i-1], win_q[nkm1_q] is w[i-Nk].
  always_comb begin
    key_ph = i_q <= {3'b000, nkm1_q};
    adv    = !sv_q || subkey_ready;
    legal  = (key_len != 2'b11)
          && ((128 + 64 * int'(key_len)) <= MAX_KEY_BITS);
    mix    = win_q[0];
    if (cnt_q == 3'd0)
      mix = sub_word({win_q[0][23:0], win_q[0][31:24]})
          ^ {rcon_q, 24'h0};
    else if (nkm1_q == 3'd7 && cnt_q == 3'd4)
      mix = sub_word(win_q[0]);
    w_d = key_ph ? key_q[255:224] : (win_q[nkm1_q] ^ mix);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      key_q    <= '0;
      i_q      <= '0;
      last_q   <= '0;
      cnt_q    <= '0;
      nkm1_q   <= '0;
      rcon_q   <= '0;
      for (int k = 0; k < 8; k++) win_q[k] <= '0;
      subkey_q <= '0;
      sv_q     <= 1'b0;
      ridx_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          ridx_q <= '0;
          if (start && legal) begin
            state_q <= GEN;
            key_q   <= short_key;
            i_q     <= '0;
            cnt_q   <= '0;
            rcon_q  <= 8'h01;
            busy_q  <= 1'b1;
            unique case (key_len)
              2'b00: begin
                nkm1_q <= 3'd3;
                last_q <= 6'd43;
              end
              2'b01: begin
                nkm1_q <= 3'd5;
                last_q <= 6'd51;
              end
              default: begin
                nkm1_q <= 3'd7;
                last_q <= 6'd59;
              end
            endcase
          end
        end
        GEN: begin
          if (adv) begin
            win_q[0] <= w_d;
            for (int k = 1; k < 8; k++) win_q[k] <= win_q[k-1];
            key_q <= {key_q[223:0], 32'h0};
            i_q   <= i_q + 6'd1;
            cnt_q <= (cnt_q == nkm1_q) ? 3'd0 : cnt_q + 3'd1;
            if (!key_ph && cnt_q == 3'd0)
              rcon_q <= {rcon_q[6:0], 1'b0}
                      ^ (rcon_q[7] ? 8'h1b : 8'h00);
            if (i_q[1:0] == 2'b11) begin
              subkey_q <= {win_q[2], win_q[1], win_q[0], w_d};
              sv_q     <= 1'b1;
              ridx_q   <= i_q[5:2];
            end else begin
              sv_q <= 1'b0;
            end
            if (i_q == last_q) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (subkey_ready) begin
            state_q <= IDLE;
            sv_q    <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            ridx_q  <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign subkey       = subkey_q;
  assign subkey_valid = sv_q;
  assign round_idx    = ridx_q;
  assign busy         = busy_q;
  assign done         = done_q;
endmodule

// File: tb/tb_aes_key_expansion_multi.sv
// Bench for aes_key_expansion_multi: known answers, back-pressure,
// reset abort and random runs against a table-based key schedule model.
module tb_aes_key_expansion_multi;
  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] short_key;
  logic [127:0] subkey;
  logic         subkey_valid;
  logic         subkey_ready;
  logic [3:0]   round_idx;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  aes_key_expansion_multi #(
    .MAX_KEY_BITS(256),
    .SBOX_INST(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .key_len(key_len),
    .short_key(short_key),
    .subkey(subkey),
    .subkey_valid(subkey_valid),
    .subkey_ready(subkey_ready),
    .round_idx(round_idx),
    .busy(busy),
    .done(done)
  );

  localparam logic [2047:0] SBOX_P = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef struct {
    logic [1:0]   kl;
    logic [255:0] key;
    int           ra;
    logic [127:0] ka;
    int           rb;
    logic [127:0] kb;
  } kat_t;

  kat_t         kat [3];
  logic [2047:0] sbox_v;
  logic [7:0]   rcon [11];
  logic [31:0]  mw [60];
  logic [127:0] acc_k [$];
  int           acc_r [$];
  int           first_v, last_acc_at, done_at, valid_cyc;
  int           n_chk = 0;
  int           n_fail = 0;

  task automatic check_v(input string nm, input logic [127:0] act,
                         input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_i(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] sb(input logic [7:0] x);
    return sbox_v[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
  endfunction

  // Full expanded key per the textbook schedule, held as a flat array.
  task automatic expand(input logic [1:0] kl, input logic [255:0] k);
    int nk;
    logic [31:0] t;
    nk = 4 + 2*int'(kl);
    for (int i = 0; i < 60; i++) mw[i] = '0;
    for (int i = 0; i < 4*(nk+7); i++) begin
      if (i < nk) begin
        mw[i] = k[255-32*i -: 32];
      end else begin
        t = mw[i-1];
        if (i % nk == 0)
          t = subw({t[23:0], t[31:24]}) ^ {rcon[i/nk], 24'h0};
        else if (nk == 8 && i % nk == 4)
          t = subw(t);
        mw[i] = mw[i-nk] ^ t;
      end
    end
  endtask

  function automatic logic [127:0] rk(input int r);
    return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endfunction

  function automatic logic [127:0] acc_at(input int r);
    logic [127:0] v;
    v = 'x;
    if (r >= 0 && r < acc_k.size()) v = acc_k[r];
    return v;
  endfunction

  // rmode: 0 ready high, 1 hold 5 cycles at round 3, 2 random ready.
  task automatic run(input string tag, input logic [1:0] kl,
                     input logic [255:0] k, input int rmode,
                     input bit poke);
    int nr, held;
    logic [127:0] hk;
    logic [3:0] hr;
    bit fin;
    nr = 10 + 2*int'(kl);
    expand(kl, k);
    acc_k.delete();
    acc_r.delete();
    first_v = -1;
    last_acc_at = -1;
    done_at = -1;
    valid_cyc = 0;
    held = 0;
    fin = 0;
    hk = '0;
    hr = '0;
    @(negedge clk);
    start = 1'b1;
    key_len = kl;
    short_key = k;
    subkey_ready = 1'b1;
    for (int n = 0; n < 400 && !fin; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke && n == 10) begin
        start = 1'b1;
        key_len = 2'b00;
        short_key = ~k;
      end
      if (n == 0) check_v({tag, " busy_up"}, {127'b0, busy}, 128'd1);
      if (done_at >= 0) begin
        check_v({tag, " done_pulse"}, {127'b0, done}, 128'd0);
        check_v({tag, " busy_down"}, {127'b0, busy}, 128'd0);
        check_v({tag, " valid_down"}, {127'b0, subkey_valid}, 128'd0);
        fin = 1;
      end else begin
        if (done) done_at = n;
        subkey_ready = 1'b1;
        if (subkey_valid) begin
          valid_cyc++;
          if (first_v < 0) first_v = n;
          if (rmode == 1 && round_idx == 4'd3 && held < 5) begin
            if (held == 0) begin
              hk = subkey;
              hr = round_idx;
            end else begin
              check_v({tag, " hold_key"}, subkey, hk);
              check_v({tag, " hold_idx"}, {124'b0, round_idx},
                      {124'b0, hr});
            end
            held++;
            subkey_ready = 1'b0;
          end else if (rmode == 2) begin
            subkey_ready = ($urandom_range(0, 2) != 0);
          end
          if (subkey_ready) begin
            acc_k.push_back(subkey);
            acc_r.push_back(int'(round_idx));
            last_acc_at = n;
          end
        end
      end
    end
    subkey_ready = 1'b1;
    check_i({tag, " finished"}, int'(fin), 1);
    check_i({tag, " n_keys"}, acc_k.size(), nr + 1);
    for (int j = 0; j < acc_k.size() && j <= nr; j++) begin
      check_i($sformatf("%s idx%0d", tag, j), acc_r[j], j);
      check_v($sformatf("%s key%0d", tag, j), acc_k[j], rk(j));
    end
    check_i({tag, " done_at"}, done_at, last_acc_at + 1);
    if (rmode == 0) begin
      check_i({tag, " first_valid"}, first_v, 4);
      check_i({tag, " valid_cycles"}, valid_cyc, nr + 1);
      check_i({tag, " last_at"}, last_acc_at, 4*nr + 4);
    end
  endtask

  task automatic check_zero(input string tag);
    check_v({tag, " subkey"}, subkey, 128'd0);
    check_v({tag, " valid"}, {127'b0, subkey_valid}, 128'd0);
    check_v({tag, " ridx"}, {124'b0, round_idx}, 128'd0);
    check_v({tag, " busy"}, {127'b0, busy}, 128'd0);
    check_v({tag, " done"}, {127'b0, done}, 128'd0);
  endtask

  initial begin
    int got;
    int bad;
    logic [255:0] rkey;
    logic [1:0] rkl;
    sbox_v = SBOX_P;
    rcon = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
             8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    kat[0] = '{2'b00,
      {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
      1, 128'ha0fafe1788542cb123a339392a6c7605,
      10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    kat[1] = '{2'b01,
      {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0},
      0, 128'h8e73b0f7da0e6452c810f32b809079e5,
      12, 128'he98ba06f448c773c8ecc720401002202};
    kat[2] = '{2'b10,
      256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
      1, 128'h1f352c073b6108d72d9810a30914dff4,
      14, 128'hfe4890d1e6188d0b046df344706c631e};

    reset = 1'b1;
    start = 1'b0;
    key_len = 2'b00;
    short_key = '0;
    subkey_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int t = 0; t < 3; t++) begin
      run($sformatf("kat%0d", t), kat[t].kl, kat[t].key, 0, 0);
      check_v($sformatf("kat%0d rkA", t), acc_at(kat[t].ra), kat[t].ka);
      check_v($sformatf("kat%0d rkB", t), acc_at(kat[t].rb), kat[t].kb);
    end

    run("hold128", 2'b00, kat[0].key, 1, 0);
    check_v("hold128 final", acc_at(10), kat[0].kb);

    run("poke256", 2'b10, kat[2].key, 0, 1);
    check_v("poke256 final", acc_at(14), kat[2].kb);

    @(negedge clk);
    start = 1'b1;
    key_len = 2'b01;
    short_key = kat[1].key;
    @(negedge clk);
    start = 1'b0;
    got = 0;
    for (int n = 0; n < 200; n++) begin
      if (subkey_valid && round_idx == 4'd6) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    check_i("abort reach_r6", got, 1);
    reset = 1'b1;
    start = 1'b1;
    key_len = 2'b00;
    @(posedge clk);
    #1;
    check_zero("abort");
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    bad = 0;
    repeat (6) begin
      if (busy || subkey_valid) bad = 1;
      @(negedge clk);
    end
    check_i("abort stays_idle", bad, 0);
    run("after_abort", 2'b00, kat[0].key, 0, 0);
    check_v("after_abort final", acc_at(10), kat[0].kb);

    @(negedge clk);
    start = 1'b1;
    key_len = 2'b11;
    short_key = kat[2].key;
    @(negedge clk);
    start = 1'b0;
    bad = 0;
    repeat (8) begin
      if (busy || subkey_valid) bad = 1;
      @(negedge clk);
    end
    check_i("illegal_len idle", bad, 0);

    for (int t = 0; t < 6; t++) begin
      rkl = 2'(t % 3);
      for (int b = 0; b < 8; b++) rkey[32*b +: 32] = $urandom();
      run($sformatf("rand%0d", t), rkl, rkey, (t < 3) ? 2 : 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
